karat_mult_ctrl: RTL and testbench

Initiator-side controller for the Karatsuba multiplier's enable/finish protocol. It accepts operand pairs over a valid/ready slave port and drives `mult_enable` and the operands into the multiplier. It waits for `mult_finish`, captures the product, and presents it on a valid/ready master port. It sits between the system datapath and `karat_mult_recursion`, and adds a watchdog timeout and a transaction counter.

---
 rtl/karat_pkg.sv | 18 +
 rtl/karat_watchdog.sv | 29 ++
 rtl/karat_mult_ctrl.sv | 131 +++++++++++++
 tb/tb_karat_mult_ctrl.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/karat_pkg.sv
// Shared types and defaults for the Karatsuba multiplier controller and its watchdog.
package karat_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } ctrl_state_t;

    localparam int KARAT_WI      = 1024;
    localparam int KARAT_TIMEOUT = 4096;

    // Counter width able to hold TIMEOUT-1; never narrower than one bit.
    function automatic int wd_width(input int timeout);
        return (timeout <= 2) ? 1 : $clog2(timeout);
    endfunction

endpackage

// File: rtl/karat_watchdog.sv
// Clearable saturating cycle counter; expired is high once the count reaches TIMEOUT-1.
module karat_watchdog
    import karat_pkg::*;
#(
    parameter int TIMEOUT = KARAT_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam int W = wd_width(TIMEOUT);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != LAST)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign expired = (r_cnt == LAST);

endmodule

// File: rtl/karat_mult_ctrl.sv
// Initiator-side controller for the Karatsuba multiplier enable/finish protocol,
// with a watchdog abort and a wrapping count of delivered results.
module karat_mult_ctrl
    import karat_pkg::*;
#(
    parameter int wI      = KARAT_WI,
    parameter int wO      = 2 * wI,
    parameter int TIMEOUT = KARAT_TIMEOUT,
    parameter int wCNT    = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [wI-1:0]   s_x,
    input  logic [wI-1:0]   s_y,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [wO-1:0]   m_prod,
    output logic            m_err,
    output logic            mult_enable,
    output logic [wI-1:0]   mult_x,
    output logic [wI-1:0]   mult_y,
    input  logic            mult_finish,
    input  logic [wO-1:0]   mult_prod,
    output logic            busy,
    output logic [wCNT-1:0] txn_cnt,
    output ctrl_state_t     o_state
);

    ctrl_state_t     r_state;
    logic            r_live;
    logic            r_m_valid;
    logic [wO-1:0]   r_m_prod;
    logic            r_m_err;
    logic            r_enable;
    logic [wI-1:0]   r_x;
    logic [wI-1:0]   r_y;
    logic            r_busy;
    logic [wCNT-1:0] r_txn_cnt;

    logic w_accept;
    logic w_expired;
    logic w_wd_inc;

    // Both ports: a transfer happens on the rising edge where valid && ready;
    // valid holds its payload until then. r_live keeps s_ready low through reset
    // and for the first cycle after release.
    assign s_ready  = r_live && ((r_state == IDLE) || ((r_state == HOLD) && m_ready));
    assign w_accept = s_valid && s_ready;
    assign w_wd_inc = (r_state == RUN) && !mult_finish;

    karat_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_accept),
        .inc     (w_wd_inc),
        .expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_live    <= 1'b0;
            r_m_valid <= 1'b0;
            r_m_prod  <= '0;
            r_m_err   <= 1'b0;
            r_enable  <= 1'b0;
            r_x       <= '0;
            r_y       <= '0;
            r_busy    <= 1'b0;
            r_txn_cnt <= '0;
        end else begin
            r_live <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_x      <= s_x;
                        r_y      <= s_y;
                        r_enable <= 1'b1;
                        r_busy   <= 1'b1;
                        r_state  <= RUN;
                    end
                end
                RUN: begin
                    // A finish arriving on the expiry cycle still delivers the product.
                    if (mult_finish) begin
                        r_m_prod  <= mult_prod;
                        r_m_err   <= 1'b0;
                        r_m_valid <= 1'b1;
                        r_enable  <= 1'b0;
                        r_state   <= HOLD;
                    end else if (w_expired) begin
                        r_m_prod  <= '0;
                        r_m_err   <= 1'b1;
                        r_m_valid <= 1'b1;
                        r_enable  <= 1'b0;
                        r_state   <= HOLD;
                    end
                end
                HOLD: begin
                    if (m_ready) begin
                        r_m_valid <= 1'b0;
                        r_txn_cnt <= r_txn_cnt + 1'b1;
                        if (w_accept) begin
                            r_x      <= s_x;
                            r_y      <= s_y;
                            r_enable <= 1'b1;
                            r_state  <= RUN;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign m_valid     = r_m_valid;
    assign m_prod      = r_m_prod;
    assign m_err       = r_m_err;
    assign mult_enable = r_enable;
    assign mult_x      = r_x;
    assign mult_y      = r_y;
    assign busy        = r_busy;
    assign txn_cnt     = r_txn_cnt;
    assign o_state     = r_state;

endmodule

// File: tb/tb_karat_mult_ctrl.sv
// Bench for karat_mult_ctrl: stub multiplier with programmable latency, table-driven
// single operations, scoreboard of expected results, and multi-cycle corner sequences.
module tb_karat_mult_ctrl;
    import karat_pkg::*;

    localparam int WI = 8;
    localparam int WO = 16;
    localparam int TO = 16;
    localparam int WC = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            s_valid = 1'b0;
    logic            s_ready;
    logic [WI-1:0]   s_x = '0;
    logic [WI-1:0]   s_y = '0;
    logic            m_valid;
    logic            m_ready = 1'b0;
    logic [WO-1:0]   m_prod;
    logic            m_err;
    logic            mult_enable;
    logic [WI-1:0]   mult_x;
    logic [WI-1:0]   mult_y;
    logic            busy;
    logic [WC-1:0]   txn_cnt;
    ctrl_state_t     o_state;

    // Stub multiplier
    int              stub_l = 5;
    logic            stub_busy = 1'b0;
    int              stub_cnt = 0;
    logic            stub_fin = 1'b0;
    logic [WO-1:0]   stub_prod = '0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [WO:0]     exp_q[$];
    logic [WI-1:0]   acc_x = '0;
    logic [WI-1:0]   acc_y = '0;
    int              acc_cyc = 0;
    int              mv_rise_cyc = 0;
    int              en_rise_cyc = 0;
    int              n_hs = 0;
    logic [WO-1:0]   hs_prod = '0;
    logic            hs_err = 1'b0;
    logic            prev_en = 1'b0;
    logic            prev_mv = 1'b0;
    logic [WC-1:0]   exp_cnt = '0;

    typedef struct {
        logic [WI-1:0] x;
        logic [WI-1:0] y;
        int            l;
        logic [WO-1:0] prod;
        logic          err;
        int            lat;
    } vec_t;
    vec_t vecs[7];

    karat_mult_ctrl #(.wI(WI), .wO(WO), .TIMEOUT(TO), .wCNT(WC)) dut (
        .clk         (clk),
        .rst         (rst),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_x         (s_x),
        .s_y         (s_y),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_prod      (m_prod),
        .m_err       (m_err),
        .mult_enable (mult_enable),
        .mult_x      (mult_x),
        .mult_y      (mult_y),
        .mult_finish (stub_fin),
        .mult_prod   (stub_prod),
        .busy        (busy),
        .txn_cnt     (txn_cnt),
        .o_state     (o_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Finish pulses in the L-th cycle of mult_enable; keeps counting through a reset.
    always @(posedge clk) begin
        stub_fin <= 1'b0;
        if (stub_busy) begin
            if (stub_cnt == stub_l - 1) begin
                stub_fin  <= 1'b1;
                stub_busy <= 1'b0;
                stub_prod <= WO'(mult_x) * WO'(mult_y);
            end else begin
                stub_cnt <= stub_cnt + 1;
            end
        end else if (mult_enable && !stub_fin && stub_l >= 2) begin
            if (stub_l == 2) begin
                stub_fin  <= 1'b1;
                stub_prod <= WO'(mult_x) * WO'(mult_y);
            end else begin
                stub_busy <= 1'b1;
                stub_cnt  <= 2;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [WO:0] model(input logic [WI-1:0] x, input logic [WI-1:0] y, input int l);
        logic [WO-1:0] p;
        p = WO'(x) * WO'(y);
        if (l < 2 || l > TO) return {1'b1, {WO{1'b0}}};
        return {1'b0, p};
    endfunction

    // Monitor / scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        prev_en <= mult_enable;
        prev_mv <= m_valid;
        if (mult_enable && !prev_en) en_rise_cyc <= cyc;
        if (!rst) begin
            if (s_valid && s_ready) begin
                exp_q.push_back(model(s_x, s_y, stub_l));
                acc_x   <= s_x;
                acc_y   <= s_y;
                acc_cyc <= cyc;
            end
            if (mult_enable) begin
                check("mult_x_stable", 32'(mult_x), 32'(acc_x));
                check("mult_y_stable", 32'(mult_y), 32'(acc_y));
            end
            if (m_valid && !prev_mv) mv_rise_cyc <= cyc;
            if (m_valid && m_ready) begin
                check("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    check("sb_prod", 32'(m_prod), 32'(exp_q[0][WO-1:0]));
                    check("sb_err", 32'(m_err), 32'(exp_q[0][WO]));
                    void'(exp_q.pop_front());
                end
                hs_prod <= m_prod;
                hs_err  <= m_err;
                n_hs    <= n_hs + 1;
            end
        end
    end

    task automatic drive_op(input logic [WI-1:0] x, input logic [WI-1:0] y, input int l);
        int n;
        bit got;
        n = 0;
        got = 0;
        stub_l  = l;
        s_x     = x;
        s_y     = y;
        s_valid = 1'b1;
        while (!got && n < 40) begin
            @(negedge clk);
            if (s_ready) got = 1;
            n++;
        end
        if (!got) check("accept_wait", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic wait_hs(input int bound);
        int n;
        bit got;
        n = 0;
        got = 0;
        while (!got && n < bound) begin
            @(negedge clk);
            if (m_valid && m_ready) got = 1;
            n++;
        end
        if (!got) check("result_wait", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_m_valid"}, 32'(m_valid), 32'd0);
        check({tag, "_m_prod"}, 32'(m_prod), 32'd0);
        check({tag, "_m_err"}, 32'(m_err), 32'd0);
        check({tag, "_mult_enable"}, 32'(mult_enable), 32'd0);
        check({tag, "_mult_x"}, 32'(mult_x), 32'd0);
        check({tag, "_mult_y"}, 32'(mult_y), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_txn_cnt"}, 32'(txn_cnt), 32'd0);
        check({tag, "_s_ready"}, 32'(s_ready), 32'd0);
        check({tag, "_state"}, 32'(o_state), 32'(IDLE));
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit: got no finish expected finish by 200000");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int b2b_cyc[4];
        logic [WI-1:0] b2b_x[4];
        logic [WI-1:0] b2b_y[4];
        int n;
        int hs0;
        int mv_seen;
        logic [WC-1:0] wrap_seq[5];

        vecs[0] = '{x: 8'hFF, y: 8'hFF, l: 5,  prod: 16'hFE01, err: 1'b0, lat: 6};
        vecs[1] = '{x: 8'h03, y: 8'h07, l: 3,  prod: 16'h0015, err: 1'b0, lat: 4};
        vecs[2] = '{x: 8'h80, y: 8'h02, l: 2,  prod: 16'h0100, err: 1'b0, lat: 3};
        vecs[3] = '{x: 8'h12, y: 8'h34, l: 7,  prod: 16'h03A8, err: 1'b0, lat: 8};
        vecs[4] = '{x: 8'hAB, y: 8'h00, l: 4,  prod: 16'h0000, err: 1'b0, lat: 5};
        vecs[5] = '{x: 8'h55, y: 8'h55, l: 0,  prod: 16'h0000, err: 1'b1, lat: 17};
        vecs[6] = '{x: 8'h0F, y: 8'h11, l: 16, prod: 16'h00FF, err: 1'b0, lat: 17};
        b2b_x = '{8'd3, 8'd0, 8'd255, 8'd16};
        b2b_y = '{8'd7, 8'd9, 8'd1, 8'd16};
        wrap_seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        rst = 1'b0;
        #1;
        check("s_ready_release_cycle", 32'(s_ready), 32'd0);
        @(posedge clk);
        #1;
        check("s_ready_idle", 32'(s_ready), 32'd1);

        // Table of single operations
        m_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            drive_op(vecs[i].x, vecs[i].y, vecs[i].l);
            wait_hs(40);
            exp_cnt = exp_cnt + 1'b1;
            check($sformatf("vec%0d_prod", i), 32'(hs_prod), 32'(vecs[i].prod));
            check($sformatf("vec%0d_err", i), 32'(hs_err), 32'(vecs[i].err));
            check($sformatf("vec%0d_latency", i), 32'(mv_rise_cyc - acc_cyc), 32'(vecs[i].lat));
            check($sformatf("vec%0d_txn_cnt", i), 32'(txn_cnt), 32'(exp_cnt));
            check($sformatf("vec%0d_idle", i), 32'(busy), 32'd0);
            if (vecs[i].err) begin
                check($sformatf("vec%0d_timeout_from_enable", i), 32'(mv_rise_cyc - en_rise_cyc), 32'(TO));
            end
        end

        // Back-to-back with s_valid held
        hs0 = n_hs;
        stub_l = 3;
        s_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bit got;
            got = 0;
            n = 0;
            s_x = b2b_x[i];
            s_y = b2b_y[i];
            while (!got && n < 30) begin
                @(negedge clk);
                if (s_ready) got = 1;
                n++;
            end
            if (!got) check("b2b_accept_wait", 32'd0, 32'd1);
            b2b_cyc[i] = cyc;
            check($sformatf("b2b%0d_enable_low", i), 32'(mult_enable), 32'd0);
            if (i > 0) check($sformatf("b2b%0d_interval", i), 32'(b2b_cyc[i] - b2b_cyc[i-1]), 32'd4);
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        n = 0;
        while (n_hs < hs0 + 4 && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("b2b_handshakes", 32'(n_hs - hs0), 32'd4);
        exp_cnt = exp_cnt + 3'd4;
        check("b2b_txn_cnt", 32'(txn_cnt), 32'(exp_cnt));

        // Backpressure
        repeat (2) @(posedge clk);
        #1;
        m_ready = 1'b0;
        drive_op(8'h21, 8'h03, 4);
        n = 0;
        while (!m_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("bp_m_valid_seen", 32'(m_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_m_valid_held", 32'(m_valid), 32'd1);
            check("bp_m_prod_held", 32'(m_prod), 32'h0063);
            check("bp_s_ready_low", 32'(s_ready), 32'd0);
            check("bp_txn_cnt_held", 32'(txn_cnt), 32'(exp_cnt));
        end
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        @(negedge clk);
        check("bp_handshake_now", 32'(m_valid && m_ready), 32'd1);
        @(posedge clk);
        #1;
        exp_cnt = exp_cnt + 1'b1;
        check("bp_m_valid_drop", 32'(m_valid), 32'd0);
        check("bp_txn_cnt_step", 32'(txn_cnt), 32'(exp_cnt));
        repeat (3) @(posedge clk);
        #1;
        check("bp_txn_cnt_once", 32'(txn_cnt), 32'(exp_cnt));

        // Reset in the middle of RUN
        drive_op(8'h5A, 8'h03, 8);
        @(posedge clk);
        #1;
        check("rr_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("midrun");
        exp_q.delete();
        exp_cnt = '0;
        rst = 1'b0;
        mv_seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (m_valid || mult_enable) mv_seen++;
        end
        check("rr_late_finish_ignored", 32'(mv_seen), 32'd0);
        check("rr_state_idle", 32'(o_state), 32'(IDLE));

        // Counter wrap with a 2-bit counter
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            drive_op(WI'(i + 1), 8'h03, 2);
            wait_hs(20);
            check($sformatf("wrap%0d_txn_cnt", i), 32'(txn_cnt), 32'(wrap_seq[i]));
        end

        repeat (4) @(posedge clk);
        #1;
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
